// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared command codes, ALU op codes and FSM state type for alu_seq
// Contents: CMD_* (3-bit cmd encoding), OP_* (4-bit ALU op codes), state_e (sequencer FSM states).
package alu_seq_pkg;
    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_ROL = 3'd2;
    localparam logic [2:0] CMD_ROR = 3'd3;
    localparam logic [2:0] CMD_OR  = 3'd4;
    localparam logic [2:0] CMD_AND = 3'd5;
    localparam logic [2:0] CMD_XOR = 3'd6;
    localparam logic [2:0] CMD_CMP = 3'd7;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_ROL = 4'b1011;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_AND = 4'b1101;
    localparam logic [3:0] OP_XOR = 4'b1110;
    localparam logic [3:0] OP_ROR = 4'b1111;
    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_e;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: command/result handshake between the CPU core and the multi-byte sequencer
// Signals: start/cmd/a_in/b_in/cin/bcd (request), busy/done (handshake), res and c/z/n/v flags (result).
// Modports: master = core side, slave = sequencer side.
interface alu_seq_if #(
    parameter int NBYTES = 2
);
    logic                start;
    logic [2:0]          cmd;
    logic [8*NBYTES-1:0] a_in;
    logic [8*NBYTES-1:0] b_in;
    logic                cin;
    logic                bcd;
    logic                busy;
    logic                done;
    logic [8*NBYTES-1:0] res;
    logic                c_out;
    logic                z_out;
    logic                n_out;
    logic                v_out;
    modport master (
        output start, cmd, a_in, b_in, cin, bcd,
        input  busy, done, res, c_out, z_out, n_out, v_out
    );
    modport slave (
        input  start, cmd, a_in, b_in, cin, bcd,
        output busy, done, res, c_out, z_out, n_out, v_out
    );
endinterface

// File: rtl/alu_seq_opdec.sv
// alu_seq_opdec: decodes a sequencer command into ALU controls and sequencing attributes
// Ports: cmd (in, 3) -> op (ALU op code), right (shift-right select), msb_first (byte order),
//        bcd_allowed (decimal mode may apply), writeback (result register is updated).
module alu_seq_opdec
    import alu_seq_pkg::*;
(
    input  logic [2:0] cmd,
    output logic [3:0] op,
    output logic       right,
    output logic       msb_first,
    output logic       bcd_allowed,
    output logic       writeback
);
    assign op = cmd == CMD_ADD ? OP_ADD :
                (cmd == CMD_SUB || cmd == CMD_CMP) ? OP_SUB :
                cmd == CMD_ROL ? OP_ROL :
                cmd == CMD_ROR ? OP_ROR :
                cmd == CMD_OR  ? OP_OR  :
                cmd == CMD_AND ? OP_AND : OP_XOR;
    assign right       = cmd == CMD_ROR;
    assign msb_first   = cmd == CMD_ROR;
    assign bcd_allowed = cmd == CMD_ADD || cmd == CMD_SUB;
    assign writeback   = cmd != CMD_CMP;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-byte sequencer feeding a 6502-style 8-bit ALU one byte per cycle with carry chaining
// Ports: clk, reset (synchronous, active high); sif (alu_seq_if.slave command/result handshake);
//        alu_op/alu_right/alu_ai/alu_bi/alu_ci/alu_bcd/alu_rdy drive the ALU;
//        alu_out/alu_co/alu_v/alu_z/alu_n are the ALU's registered results.
// Build option: ALU_SEQ_BCD_EN honours sif.bcd for ADD/SUB; otherwise alu_bcd is tied 0.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   sif,
    output logic [3:0] alu_op,
    output logic       alu_right,
    output logic [7:0] alu_ai,
    output logic [7:0] alu_bi,
    output logic       alu_ci,
    output logic       alu_bcd,
    output logic       alu_rdy,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_n
);
    localparam logic [1:0] LAST = 2'(NBYTES - 1);

    state_e              state, state_nx;
    logic [1:0]          cnt, byte_idx, cap_pos, cap_idx;
    logic [8*NBYTES-1:0] a_r, b_r, acc, acc_nx;
    logic [2:0]          cmd_r;
    logic                cin_r, bcd_r, z_acc, n_acc, v_acc, z_nx, n_nx, v_nx, cap_en, issue;
    logic [3:0]          op;
    logic                right, msb_first, bcd_allowed, writeback;

    alu_seq_opdec u_opdec (
        .cmd         (cmd_r),
        .op          (op),
        .right       (right),
        .msb_first   (msb_first),
        .bcd_allowed (bcd_allowed),
        .writeback   (writeback)
    );

    assign state_nx = state == IDLE  ? (sif.start ? ISSUE : IDLE) :
                      state == ISSUE ? (cnt == LAST ? FLUSH : ISSUE) : IDLE;
    assign sif.busy = state != IDLE;

    // The ALU result lags the issued byte by one cycle, so the byte being captured
    // is the one issued at cnt-1 (or at cnt once issuing has stopped in FLUSH).
    always_comb begin
        issue    = state == ISSUE;
        byte_idx = msb_first ? LAST - cnt : cnt;
        cap_en   = state == FLUSH || (issue && cnt != 2'd0);
        cap_pos  = state == FLUSH ? cnt : cnt - 2'd1;
        cap_idx  = msb_first ? LAST - cap_pos : cap_pos;
        acc_nx   = acc;
        if (cap_en) acc_nx[{cap_idx, 3'b000} +: 8] = alu_out;
        z_nx      = cap_en ? z_acc & alu_z : z_acc;
        n_nx      = (cap_en && cap_idx == LAST) ? alu_n : n_acc;
        v_nx      = (cap_en && cap_idx == LAST) ? alu_v : v_acc;
        alu_rdy   = issue;
        alu_op    = issue ? op : 4'd0;
        alu_right = issue & right;
        alu_ai    = issue ? a_r[{byte_idx, 3'b000} +: 8] : 8'd0;
        alu_bi    = issue ? b_r[{byte_idx, 3'b000} +: 8] : 8'd0;
        alu_ci    = issue & (cnt == 2'd0 ? cin_r : alu_co);
`ifdef ALU_SEQ_BCD_EN
        alu_bcd   = issue & bcd_r & bcd_allowed;
`else
        alu_bcd   = 1'b0;
`endif
    end

`ifndef ALU_SEQ_BCD_EN
    logic unused_bcd;
    assign unused_bcd = bcd_r ^ bcd_allowed;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cmd_r     <= '0;
            cin_r     <= 1'b0;
            bcd_r     <= 1'b0;
            acc       <= '0;
            z_acc     <= 1'b0;
            n_acc     <= 1'b0;
            v_acc     <= 1'b0;
            sif.done  <= 1'b0;
            sif.res   <= '0;
            sif.c_out <= 1'b0;
            sif.z_out <= 1'b0;
            sif.n_out <= 1'b0;
            sif.v_out <= 1'b0;
        end else begin
            state    <= state_nx;
            sif.done <= state == FLUSH;
            if (state == IDLE && sif.start) begin
                a_r   <= sif.a_in;
                b_r   <= sif.b_in;
                cmd_r <= sif.cmd;
                cin_r <= sif.cin;
                bcd_r <= sif.bcd;
                cnt   <= '0;
                acc   <= '0;
                z_acc <= 1'b1;
                n_acc <= 1'b0;
                v_acc <= 1'b0;
            end
            if (issue) begin
                cnt   <= cnt == LAST ? cnt : cnt + 2'd1;
                acc   <= acc_nx;
                z_acc <= z_nx;
                n_acc <= n_nx;
                v_acc <= v_nx;
            end
            if (state == FLUSH) begin
                if (writeback) sif.res <= acc_nx;
                sif.c_out <= alu_co;
                sif.z_out <= z_nx;
                sif.n_out <= n_nx;
                sif.v_out <= v_nx;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq with a behavioural registered 6502-style ALU
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] alu_op;
    logic       alu_right, alu_ci, alu_bcd, alu_rdy;
    logic [7:0] alu_ai, alu_bi;
    logic [7:0] alu_out;
    logic       alu_co, alu_v, alu_z, alu_n;
    int         tests = 0;
    int         fails = 0;
    int         lat, dones;

    alu_seq_if #(.NBYTES(2)) sif ();

    alu_seq #(.NBYTES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .sif       (sif),
        .alu_op    (alu_op),
        .alu_right (alu_right),
        .alu_ai    (alu_ai),
        .alu_bi    (alu_bi),
        .alu_ci    (alu_ci),
        .alu_bcd   (alu_bcd),
        .alu_rdy   (alu_rdy),
        .alu_out   (alu_out),
        .alu_co    (alu_co),
        .alu_v     (alu_v),
        .alu_z     (alu_z),
        .alu_n     (alu_n)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: logic/shift front end, adder with op-dependent second operand,
    // decimal adjust for addition, results registered while alu_rdy is high.
    logic [7:0] tl, tbi, m_res;
    logic [8:0] s;
    logic [4:0] lo;
    logic [4:0] hi;
    logic       aci, m_co, hc;
    always_comb begin
        tl  = alu_op[1:0] == 2'b00 ? (alu_ai | alu_bi) :
              alu_op[1:0] == 2'b01 ? (alu_ai & alu_bi) :
              alu_op[1:0] == 2'b10 ? (alu_ai ^ alu_bi) : alu_ai;
        if (alu_right) tl = {alu_ci, alu_ai[7:1]};
        tbi = alu_op[3:2] == 2'b00 ? alu_bi :
              alu_op[3:2] == 2'b01 ? ~alu_bi :
              alu_op[3:2] == 2'b10 ? tl : 8'd0;
        aci = (alu_right || alu_op[3:2] == 2'b11) ? 1'b0 : alu_ci;
        s   = {1'b0, tl} + {1'b0, tbi} + {8'd0, aci};
        m_res = s[7:0];
        m_co  = alu_right ? alu_ai[0] : s[8];
        lo = 5'd0;
        hi = 5'd0;
        hc = 1'b0;
        if (alu_bcd && alu_op[3:2] == 2'b00) begin
            lo = {1'b0, alu_ai[3:0]} + {1'b0, alu_bi[3:0]} + {4'd0, alu_ci};
            hc = lo > 5'd9;
            hi = {1'b0, alu_ai[7:4]} + {1'b0, alu_bi[7:4]} + {4'd0, hc};
            m_co = hi > 5'd9;
            m_res = {hi[3:0] + (m_co ? 4'd6 : 4'd0), lo[3:0] + (hc ? 4'd6 : 4'd0)};
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out <= 8'd0;
            alu_co  <= 1'b0;
            alu_v   <= 1'b0;
            alu_z   <= 1'b0;
            alu_n   <= 1'b0;
        end else if (alu_rdy) begin
            alu_out <= m_res;
            alu_co  <= m_co;
            alu_v   <= (tl[7] ^ s[7]) & (tbi[7] ^ s[7]);
            alu_z   <= m_res == 8'd0;
            alu_n   <= m_res[7];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one command and waits (bounded) for done; leaves time in the done cycle.
    task automatic run(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic bc, input logic [3:0] op, input logic rt);
        sif.cmd   = c;
        sif.a_in  = a;
        sif.b_in  = b;
        sif.cin   = ci;
        sif.bcd   = bc;
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        check("busy_after_accept", {31'd0, sif.busy}, 32'd1);
        check("alu_rdy_issue", {31'd0, alu_rdy}, 32'd1);
        check("alu_op", {28'd0, alu_op}, {28'd0, op});
        check("alu_right", {31'd0, alu_right}, {31'd0, rt});
        lat = 1;
        while (!sif.done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 4);
        check("busy_in_done", {31'd0, sif.busy}, 32'd0);
    endtask

    initial begin
        sif.start = 1'b0;
        sif.cmd   = 3'd0;
        sif.a_in  = 16'd0;
        sif.b_in  = 16'd0;
        sif.cin   = 1'b0;
        sif.bcd   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_busy", {31'd0, sif.busy}, 32'd0);
        check("rst_done", {31'd0, sif.done}, 32'd0);
        check("rst_res", {16'd0, sif.res}, 32'd0);
        check("rst_flags", {28'd0, sif.c_out, sif.z_out, sif.n_out, sif.v_out}, 32'd0);
        check("rst_alu_rdy", {31'd0, alu_rdy}, 32'd0);
        check("rst_alu_bus", {10'd0, alu_op, alu_right, alu_ci, alu_bcd, alu_ai, alu_bi}, 32'd0);
        @(posedge clk); #1;

        run(CMD_ADD, 16'h12FF, 16'h0001, 1'b0, 1'b0, OP_ADD, 1'b0);
        check("add_res", {16'd0, sif.res}, 32'h1300);
        check("add_czn", {29'd0, sif.c_out, sif.z_out, sif.n_out}, 32'b000);

        run(CMD_SUB, 16'h0000, 16'h0001, 1'b1, 1'b0, OP_SUB, 1'b0);
        check("sub_res", {16'd0, sif.res}, 32'hFFFF);
        check("sub_czn", {29'd0, sif.c_out, sif.z_out, sif.n_out}, 32'b001);

        run(CMD_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, OP_ADD, 1'b0);
        check("ovf_res", {16'd0, sif.res}, 32'h8000);
        check("ovf_vn", {30'd0, sif.v_out, sif.n_out}, 32'b11);

        run(CMD_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, OP_ADD, 1'b0);
        check("wrap_res", {16'd0, sif.res}, 32'h0000);
        check("wrap_cz", {30'd0, sif.c_out, sif.z_out}, 32'b11);

        run(CMD_CMP, 16'h1234, 16'h1234, 1'b1, 1'b0, OP_SUB, 1'b0);
        check("cmp_res_kept", {16'd0, sif.res}, 32'h0000);
        check("cmp_cz", {30'd0, sif.c_out, sif.z_out}, 32'b11);

        run(CMD_ROR, 16'h0003, 16'h0000, 1'b1, 1'b0, OP_ROR, 1'b1);
        check("ror_res", {16'd0, sif.res}, 32'h8001);
        check("ror_cn", {30'd0, sif.c_out, sif.n_out}, 32'b11);

        run(CMD_ROL, 16'h8001, 16'h0000, 1'b0, 1'b0, OP_ROL, 1'b0);
        check("rol_res", {16'd0, sif.res}, 32'h0002);
        check("rol_czn", {29'd0, sif.c_out, sif.z_out, sif.n_out}, 32'b100);

        run(CMD_ADD, 16'h0999, 16'h0001, 1'b0, 1'b1, OP_ADD, 1'b0);
`ifdef ALU_SEQ_BCD_EN
        check("bcd_res", {16'd0, sif.res}, 32'h1000);
        check("bcd_c", {31'd0, sif.c_out}, 32'd0);
`else
        check("bcd_res", {16'd0, sif.res}, 32'h099A);
        check("bcd_c", {31'd0, sif.c_out}, 32'd0);
`endif

        // Reset during the second busy cycle discards the command.
        sif.cmd   = CMD_ADD;
        sif.a_in  = 16'h1234;
        sif.b_in  = 16'h1111;
        sif.cin   = 1'b0;
        sif.bcd   = 1'b0;
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        check("rst_mid_busy1", {31'd0, sif.busy}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, sif.busy}, 32'd0);
        check("rst_mid_res", {16'd0, sif.res}, 32'd0);
        check("rst_mid_flags", {28'd0, sif.c_out, sif.z_out, sif.n_out, sif.v_out}, 32'd0);
        dones = 0;
        repeat (6) begin
            if (sif.done) dones++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_done", dones, 0);

        // A start while busy is ignored: one done, first command's result.
        sif.cmd   = CMD_ADD;
        sif.a_in  = 16'h0001;
        sif.b_in  = 16'h0001;
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        @(posedge clk); #1;
        sif.a_in  = 16'h1111;
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        dones = 0;
        repeat (8) begin
            if (sif.done) dones++;
            @(posedge clk); #1;
        end
        check("busy_start_one_done", dones, 1);
        check("busy_start_res", {16'd0, sif.res}, 32'h0002);
        check("busy_start_idle", {31'd0, sif.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-byte arithmetic sequencer for the 6502-style 8-bit ALU. It accepts one command on multi-byte operands and feeds the ALU one byte per cycle, chaining the ALU carry-out into the next byte's carry-in. It accumulates the result bytes and NZCV flags, then reports completion with a done pulse. It sits between the CPU/microcode core and the ALU instance, and it owns the ALU's op, right, AI, BI, CI, BCD and RDY inputs.

## Interface
- NBYTES, 2, operand width in bytes; legal range 1..4.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command request; accepted only when busy=0.
- cmd  in  3  0 ADD, 1 SUB, 2 ROL, 3 ROR, 4 OR, 5 AND, 6 XOR, 7 CMP.
- a_in, b_in  in  8*NBYTES  operands, sampled on accept.
- cin  in  1  carry-in for the first byte, sampled on accept.
- bcd  in  1  decimal mode for ADD/SUB, sampled on accept.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; res and flags are valid from this cycle on.
- res  out  8*NBYTES  result.
- c_out, z_out, n_out, v_out  out  1 each  result flags.
- alu_op  out  4  ALU op code.
- alu_right  out  1  ALU right-shift select.
- alu_ai, alu_bi  out  8 each  ALU operand bytes.
- alu_ci  out  1  ALU carry-in.
- alu_bcd  out  1  ALU decimal-mode select.
- alu_rdy  out  1  ALU clock enable.
- alu_out  in  8  ALU registered result byte.
- alu_co, alu_v, alu_z, alu_n  in  1 each  ALU registered flags.

## Operation
- Command to ALU mapping:
  - ADD: op 0011.
  - SUB and CMP: op 0111.
  - ROL: op 1011.
  - ROR: op 1111 with alu_right=1.
  - OR, AND, XOR: op 1100, 1101, 1110; alu_ci is don't-care.
  - alu_right=0 for every command except ROR.
- Byte order: LSB first for every command except ROR, which runs MSB first.
- Carry: alu_ci = cin for the first byte. For each later byte, alu_ci = alu_co from the previous byte, used combinationally in the capture cycle.
- SUB and CMP use 6502 borrow convention: cin=1 means no borrow.
- ROL with cin=0 is ASL.
- z_out = AND of alu_z over all bytes.
- n_out is taken from the MSB result byte.
- v_out is taken from the MSB byte's capture. It is meaningful for ADD/SUB/CMP only.
- c_out is taken from the last processed byte.
- CMP updates the flags only; res keeps its previous value.
- alu_bcd = bcd for ADD/SUB only; 0 for all other commands.
- FSM states:
  - IDLE: on start, latch operands and go to ISSUE with cnt=0.
  - ISSUE: alu_rdy=1. Drive byte cnt. Capture the previous byte's result when cnt>0. When cnt=NBYTES-1, go to FLUSH.
  - FLUSH: alu_rdy=0. Capture the last byte and compute flags. Go to IDLE, with done registered high in the next cycle.
- start while busy is ignored; no queueing.
- start coincident with the done cycle is accepted, because busy=0 during done.
- Outputs hold their last value until the next command completes.

## Timing
- Reset values: state IDLE, busy=0, done=0, res=0, all flags 0, alu_rdy=0, and all alu_* outputs 0.
- With start accepted at edge T:
  - byte k is issued in cycle T+1+k;
  - FLUSH occurs in cycle T+NBYTES+1;
  - done is high in cycle T+NBYTES+2.
- Latency is NBYTES+2 cycles from accept to done. Throughput is one command per NBYTES+2 cycles.
- Reset in any cycle:
  - return to IDLE next edge;
  - the in-flight command is discarded with no done pulse;
  - res and flags are cleared.
- alu_rdy is low in IDLE and FLUSH, so the ALU registers hold their values.

## Configuration
- ALU_SEQ_BCD_EN defined: the bcd input is honoured for ADD/SUB.
- ALU_SEQ_BCD_EN undefined: alu_bcd is tied 0 and bcd is ignored. The port remains present.

## Structure
- Package alu_seq_pkg holds:
  - the cmd encoding constants;
  - the ALU op constants (0011, 0111, 1011, 1100, 1101, 1110, 1111);
  - the FSM state typedef.
- Sub-module alu_seq_opdec: combinational cmd → {alu_op, alu_right, msb_first, bcd_allowed, writeback}.

## Test plan
All scenarios use NBYTES=2.
- ADD 0x12FF+0x0001, cin=0: res=0x1300, c=0, z=0, n=0. done exactly 4 cycles after accept.
- SUB 0x0000-0x0001, cin=1: res=0xFFFF, c=0, n=1, z=0. Separately, ADD 0x7FFF+0x0001: res=0x8000, v=1, n=1.
- ADD 0xFFFF+0x0001, cin=0: res=0x0000, c=1, z=1. Then CMP 0x1234 vs 0x1234, cin=1: res stays 0x0000, z=1, c=1.
- ROR 0x0003, cin=1: res=0x8001, c=1, n=1. ROL 0x8001, cin=0: res=0x0002, c=1.
- BCD ADD 0x0999+0x0001, cin=0, bcd=1:
  - with macro: res=0x1000, c=0;
  - without macro: res=0x099A.
- Reset and busy behaviour:
  - start, then pulse reset in the 2nd busy cycle: no done pulse, res=0, busy=0 the next cycle;
  - a second start pulsed while busy is ignored, with only one done pulse observed.
